// File: rtl/mem_bank_ctrl_pkg.sv
// Shared types for mem_bank_ctrl.
// Optional read-during-write forwarding: MEM_BANK_CTRL_FWD_EN.
package mem_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    START,
    SWEEP,
    RUN
  } state_t;

  typedef logic rd_id_t;

  localparam int OUTPUT_DELAY_MAX = 2;

endpackage

// File: rtl/mem_bank_ctrl_rr_arb2.sv
// Two-input round-robin read arbiter.
// Pointer resets so that reader 0 wins the first tie.
module rr_arb2
  import mem_bank_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rd_id_t last_q;

  // grant the lone requester, or the one not served last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // remember which reader won the last granted cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_bank_ctrl.sv
// Sweep, write-priority and read round-robin control for one SDP bank.
// Define MEM_BANK_CTRL_FWD_EN to forward same-cycle write data to reads.
module mem_bank_ctrl
  import mem_bank_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    DEPTH        = 32,
  parameter int                    OUTPUT_DELAY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  localparam int                   AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  pipe_wr_en,
  input  logic [AW-1:0]         pipe_wr_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wr_data,
  output logic                  pipe_wr_drop,
  input  logic                  host_wr_req,
  input  logic [AW-1:0]         host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ack,
  input  logic [1:0]            rd_req,
  input  logic [AW-1:0]         rd_addr0,
  input  logic [AW-1:0]         rd_addr1,
  output logic [1:0]            rd_gnt,
  output logic                  rd_valid,
  output rd_id_t                rd_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_wea,
  output logic [AW-1:0]         mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dia,
  output logic                  mem_reb,
  output logic [AW-1:0]         mem_addrb,
  input  logic [DATA_WIDTH-1:0] mem_dob
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  if (OUTPUT_DELAY < 0 || OUTPUT_DELAY > OUTPUT_DELAY_MAX) begin : g_bad_delay
    $error("mem_bank_ctrl: OUTPUT_DELAY must be 0, 1 or 2");
  end

  typedef struct packed {
    logic                  valid;
    rd_id_t                id;
`ifdef MEM_BANK_CTRL_FWD_EN
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
`endif
  } ret_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  ret_t          ret_in, ret_out;

  assign busy = (state_q != RUN);

  // state and sweep counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state; counter only advances inside a sweep
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      START: state_d = SWEEP;
      SWEEP: begin
        if (cnt_q == LAST) state_d = RUN;
        else cnt_d = cnt_q + 1'b1;
      end
      RUN: if (clear_req) state_d = SWEEP;
      default: state_d = START;
    endcase
  end

  // write port: sweep, then pipe over host
  always_comb begin
    mem_wea      = 1'b0;
    mem_addra    = '0;
    mem_dia      = '0;
    pipe_wr_drop = 1'b0;
    host_wr_ack  = 1'b0;
    if (state_q == SWEEP) begin
      mem_wea   = 1'b1;
      mem_addra = cnt_q;
      mem_dia   = INIT_VALUE;
    end
    if (busy) begin
      pipe_wr_drop = pipe_wr_en;
    end else if (pipe_wr_en) begin
      mem_wea   = 1'b1;
      mem_addra = pipe_wr_addr;
      mem_dia   = pipe_wr_data;
    end else if (host_wr_req) begin
      mem_wea     = 1'b1;
      mem_addra   = host_wr_addr;
      mem_dia     = host_wr_data;
      host_wr_ack = 1'b1;
    end
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (!busy),
    .req     (rd_req),
    .gnt     (rd_gnt)
  );

  assign mem_reb   = |rd_gnt;
  assign mem_addrb = rd_gnt[1] ? rd_addr1 :
                     rd_gnt[0] ? rd_addr0 : '0;

  // tag entering the return delay line
  always_comb begin
    ret_in       = '0;
    ret_in.valid = mem_reb;
    ret_in.id    = rd_gnt[1];
`ifdef MEM_BANK_CTRL_FWD_EN
    ret_in.hit   = mem_wea && (mem_addra == mem_addrb);
    ret_in.data  = mem_dia;
`endif
  end

  if (OUTPUT_DELAY == 0) begin : g_nodly
    assign ret_out = ret_in;
  end else begin : g_dly
    ret_t pipe_q [OUTPUT_DELAY];

    // shift the tag alongside the bank read latency
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < OUTPUT_DELAY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= ret_in;
        for (int i = 1; i < OUTPUT_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign ret_out = pipe_q[OUTPUT_DELAY-1];
  end

  assign rd_valid = ret_out.valid;
  assign rd_id    = ret_out.id;

`ifdef MEM_BANK_CTRL_FWD_EN
  assign rd_data = !ret_out.valid ? '0 :
                   ret_out.hit ? ret_out.data : mem_dob;
`else
  assign rd_data = ret_out.valid ? mem_dob : '0;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl with a behavioural 2-cycle bank.
// Expected read-during-write result follows MEM_BANK_CTRL_FWD_EN.
module tb_mem_bank_ctrl;

  logic       clk;
  logic       reset_n;
  logic       clear_req;
  logic       busy;
  logic       pipe_wr_en;
  logic [4:0] pipe_wr_addr;
  logic [7:0] pipe_wr_data;
  logic       pipe_wr_drop;
  logic       host_wr_req;
  logic [4:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       host_wr_ack;
  logic [1:0] rd_req;
  logic [4:0] rd_addr0;
  logic [4:0] rd_addr1;
  logic [1:0] rd_gnt;
  logic       rd_valid;
  logic       rd_id;
  logic [7:0] rd_data;
  logic       mem_wea;
  logic [4:0] mem_addra;
  logic [7:0] mem_dia;
  logic       mem_reb;
  logic [4:0] mem_addrb;
  logic [7:0] mem_dob;

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] fwd_exp;

  mem_bank_ctrl #(
    .DATA_WIDTH   (8),
    .DEPTH        (32),
    .OUTPUT_DELAY (2),
    .INIT_VALUE   (8'h5A)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_req    (clear_req),
    .busy         (busy),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_wr_addr (pipe_wr_addr),
    .pipe_wr_data (pipe_wr_data),
    .pipe_wr_drop (pipe_wr_drop),
    .host_wr_req  (host_wr_req),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .rd_req       (rd_req),
    .rd_addr0     (rd_addr0),
    .rd_addr1     (rd_addr1),
    .rd_gnt       (rd_gnt),
    .rd_valid     (rd_valid),
    .rd_id        (rd_id),
    .rd_data      (rd_data),
    .mem_wea      (mem_wea),
    .mem_addra    (mem_addra),
    .mem_dia      (mem_dia),
    .mem_reb      (mem_reb),
    .mem_addrb    (mem_addrb),
    .mem_dob      (mem_dob)
  );

  // bank model: read-before-write, two-cycle read latency
  logic [7:0] bank [32];
  logic [7:0] q1, q2;
  always_ff @(posedge clk) begin
    if (mem_wea) bank[mem_addra] <= mem_dia;
    if (mem_reb) q1 <= bank[mem_addrb];
    q2 <= q1;
  end
  assign mem_dob = q2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // full sweep from reset release; optional stimulus while busy
  task automatic run_sweep(input bit inject);
    chk("c0_busy", busy, 1);
    chk("c0_wea", mem_wea, 0);
    for (int k = 1; k <= 33; k++) begin
      step();
      pipe_wr_en   = inject && (k == 5);
      pipe_wr_addr = 5'd20;
      pipe_wr_data = 8'hFF;
      host_wr_req  = inject && (k == 7);
      host_wr_addr = 5'd6;
      host_wr_data = 8'h77;
      clear_req    = inject && (k == 10);
      smp();
      chk("sw_wea", mem_wea, k <= 32);
      chk("sw_busy", busy, k <= 32);
      if (k <= 32) begin
        chk("sw_addra", mem_addra, k - 1);
        chk("sw_dia", mem_dia, 8'h5A);
      end
      if (inject && k == 5) chk("sw_drop", pipe_wr_drop, 1);
      if (inject && k == 7) chk("sw_noack", host_wr_ack, 0);
      if (inject && k == 9) chk("sw_gnt0", rd_gnt, 0);
    end
  endtask

  initial begin
`ifdef MEM_BANK_CTRL_FWD_EN
    fwd_exp = 8'hC3;
`else
    fwd_exp = 8'h5A;
`endif
    reset_n = 1'b0; clear_req = 1'b0;
    pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
    host_wr_req = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0;

    repeat (2) smp();
    chk("rst_busy", busy, 1);
    chk("rst_wea", mem_wea, 0);
    chk("rst_addra", mem_addra, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_reb", mem_reb, 0);
    #2 reset_n = 1'b1;
    #1;
    run_sweep(1'b1);

    // pipe and host collide: pipe first, host next cycle
    step();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3; pipe_wr_data = 8'h11;
    host_wr_req = 1'b1; host_wr_addr = 5'd4; host_wr_data = 8'h22;
    smp();
    chk("wp_wea", mem_wea, 1);
    chk("wp_addra", mem_addra, 3);
    chk("wp_dia", mem_dia, 8'h11);
    chk("wp_ack", host_wr_ack, 0);
    chk("wp_drop", pipe_wr_drop, 0);
    step();
    pipe_wr_en = 1'b0;
    smp();
    chk("hw_wea", mem_wea, 1);
    chk("hw_addra", mem_addra, 4);
    chk("hw_dia", mem_dia, 8'h22);
    chk("hw_ack", host_wr_ack, 1);
    step();
    host_wr_req = 1'b0;
    smp();
    chk("idle_wea", mem_wea, 0);
    chk("idle_ack", host_wr_ack, 0);

    // both readers continuously: 0,1,0,1
    rd_addr0 = 5'd3;
    rd_addr1 = 5'd4;
    for (int k = 0; k < 6; k++) begin
      step();
      rd_req = (k < 4) ? 2'b11 : 2'b00;
      smp();
      if (k < 4) begin
        chk("rr_gnt", rd_gnt, (k % 2 == 0) ? 1 : 2);
        chk("rr_addrb", mem_addrb, (k % 2 == 0) ? 3 : 4);
      end
      chk("rr_valid", rd_valid, k >= 2);
      if (k >= 2) begin
        chk("rr_id", rd_id, k % 2);
        chk("rr_data", rd_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      end
    end

    // single reader 1 at address 17
    step();
    rd_req = 2'b10; rd_addr1 = 5'd17;
    smp();
    chk("r17_gnt", rd_gnt, 2);
    chk("r17_reb", mem_reb, 1);
    chk("r17_addrb", mem_addrb, 17);
    step();
    rd_req = 2'b00;
    smp();
    chk("r17_v0", rd_valid, 0);
    chk("r17_d0", rd_data, 0);
    step();
    smp();
    chk("r17_valid", rd_valid, 1);
    chk("r17_id", rd_id, 1);
    chk("r17_data", rd_data, 8'h5A);

    // read-during-write at address 9
    step();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd9; pipe_wr_data = 8'hC3;
    rd_req = 2'b01; rd_addr0 = 5'd9;
    smp();
    chk("rw_gnt", rd_gnt, 1);
    chk("rw_wea", mem_wea, 1);
    step();
    pipe_wr_en = 1'b0; rd_req = 2'b00;
    smp();
    step();
    smp();
    chk("rw_valid", rd_valid, 1);
    chk("rw_id", rd_id, 0);
    chk("rw_data", rd_data, fwd_exp);

    // clear with a read granted in the same cycle
    step();
    clear_req = 1'b1; rd_req = 2'b01;
    smp();
    chk("cl_gnt", rd_gnt, 1);
    chk("cl_busy", busy, 0);
    step();
    clear_req = 1'b0;
    smp();
    chk("cl_busy1", busy, 1);
    chk("cl_gnt0", rd_gnt, 0);
    chk("cl_wea", mem_wea, 1);
    chk("cl_addra0", mem_addra, 0);
    step();
    rd_req = 2'b00;
    smp();
    chk("cl_valid", rd_valid, 1);
    chk("cl_data", rd_data, 8'hC3);
    chk("cl_addra1", mem_addra, 1);
    for (int j = 2; j <= 10; j++) begin
      step();
      smp();
      chk("cl_addra", mem_addra, j);
    end

    // reset at counter 10: sweep restarts from 0
    reset_n = 1'b0;
    #1;
    chk("mr_busy", busy, 1);
    chk("mr_wea", mem_wea, 0);
    chk("mr_addra", mem_addra, 0);
    @(posedge clk);
    smp();
    #2 reset_n = 1'b1;
    #1;
    run_sweep(1'b0);

    // reset with a read in flight: no return
    step();
    rd_req = 2'b01; rd_addr0 = 5'd5;
    smp();
    chk("fl_gnt", rd_gnt, 1);
    step();
    rd_req = 2'b00;
    smp();
    reset_n = 1'b0;
    #1;
    chk("fl_v0", rd_valid, 0);
    @(posedge clk);
    #1;
    chk("fl_v1", rd_valid, 0);
    smp();
    #2 reset_n = 1'b1;
    #1;
    chk("fl_v2", rd_valid, 0);
    step();
    smp();
    chk("fl_v3", rd_valid, 0);
    chk("fl_wea", mem_wea, 1);
    chk("fl_addra", mem_addra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
